// File: rtl/frame_wr_dma.sv
// Camera-to-DDR3 frame writer: packs RGB565 pixels into 128-bit words, queues them
// in a word FIFO and issues fixed-length write bursts into a triple frame buffer.
module frame_wr_dma #(
  parameter int unsigned           ADDR_WIDTH   = 28,
  parameter int unsigned           DATA_WIDTH   = 128,
  parameter int unsigned           BURST_LEN    = 16,
  parameter int unsigned           FIFO_DEPTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = 'h0200000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [15:0]           pix_data,
  input  logic                  init_calib_complete,
  input  logic                  cmd_ready,
  output logic [2:0]            cmd,
  output logic                  cmd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [5:0]            app_burst_number,
  input  logic                  wr_data_rdy,
  output logic                  wr_data_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_end,
  output logic [15:0]           wr_data_mask,
  output logic                  frame_done,
  output logic [1:0]            last_frame_idx,
  output logic                  overflow
);

  localparam int unsigned PIX_PER_WORD = DATA_WIDTH / 16;
  localparam int unsigned PW = $clog2(PIX_PER_WORD);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN * 8);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;
  state_t state, state_nxt;

  logic                  pend, started;
  logic [PW-1:0]         pack_cnt;
  logic [DATA_WIDTH-1:0] pack_word, push_word, word_nxt;
  logic                  push_pend;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FW-1:0]         wr_ptr, rd_ptr;
  logic [FW:0]           fifo_cnt;
  logic [BW-1:0]         beat_cnt;
  logic [1:0]            idx, idx_nxt;
  logic [ADDR_WIDTH-1:0] base_addr, base_nxt, cur_addr, addr_inc;
  logic                  do_switch, pix_take, pack_full, fifo_full, fifo_push, fifo_pop;

  assign do_switch = pend && (state == S_IDLE);
  assign pix_take  = pix_valid && !pend && !frame_start;
  assign pack_full = pix_take && (pack_cnt == PW'(PIX_PER_WORD - 1));
  assign fifo_full = (fifo_cnt == (FW+1)'(FIFO_DEPTH));
  // A flush in the same cycle as a staged push wins: the word belongs to the old frame.
  assign fifo_push = push_pend && !do_switch && !fifo_full;
  assign fifo_pop  = wr_data_en;

  assign idx_nxt  = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  assign addr_inc = cur_addr + ADDR_STEP;

  always_comb begin
    word_nxt = pack_word;
    word_nxt[16*pack_cnt +: 16] = pix_data;
  end

  always_comb begin
    case (idx_nxt)
      2'd0:    base_nxt = '0;
      2'd1:    base_nxt = FRAME_STRIDE;
      default: base_nxt = FRAME_STRIDE << 1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_cnt  <= '0;
      pack_word <= '0;
      push_word <= '0;
      push_pend <= 1'b0;
    end else begin
      push_pend <= pack_full;
      if (pack_full) push_word <= word_nxt;
      if (do_switch) begin
        pack_cnt <= '0;
      end else if (pix_take) begin
        pack_word <= word_nxt;
        pack_cnt  <= pack_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (do_switch) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + FW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + FW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (FW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (FW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (wr_data_en) beat_cnt <= wr_data_end ? '0 : beat_cnt + BW'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_en      = 1'b0;
    wr_data_en  = 1'b0;
    wr_data_end = 1'b0;
    case (state)
      S_IDLE:
        if (!pend && init_calib_complete && (fifo_cnt >= (FW+1)'(BURST_LEN)))
          state_nxt = S_CMD;
      S_CMD: begin
        cmd_en = 1'b1;
        if (cmd_ready) state_nxt = S_DATA;
      end
      S_DATA: begin
        wr_data_en  = wr_data_rdy;
        wr_data_end = wr_data_rdy && (beat_cnt == BW'(BURST_LEN - 1));
        if (wr_data_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cmd              = 3'b000;
  assign addr             = cur_addr;
  assign wr_data          = mem[rd_ptr];
  assign app_burst_number = 6'(BURST_LEN - 1);
  assign wr_data_mask     = '0;

  // The first switch after reset only opens buffer 0; later switches close idx and move on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend           <= 1'b0;
      started        <= 1'b0;
      idx            <= '0;
      last_frame_idx <= '0;
      base_addr      <= '0;
      cur_addr       <= '0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start)    pend <= 1'b1;
      else if (do_switch) pend <= 1'b0;
      if (do_switch) begin
        started  <= 1'b1;
        overflow <= 1'b0;
        if (started) begin
          last_frame_idx <= idx;
          idx            <= idx_nxt;
          base_addr      <= base_nxt;
          cur_addr       <= base_nxt;
          frame_done     <= 1'b1;
        end else begin
          cur_addr <= base_addr;
        end
      end else begin
        if (push_pend && fifo_full) overflow <= 1'b1;
        if (wr_data_end)
          cur_addr <= ((addr_inc - base_addr) >= FRAME_STRIDE) ? base_addr : addr_inc;
      end
    end
  end

endmodule

// File: tb/tb_frame_wr_dma.sv
// Self-checking bench for frame_wr_dma: a frame-level model (words = pixels/8,
// bursts = words/16, buffers cycling 0,1,2) checked against captured bus traffic.
module tb_frame_wr_dma;

  logic         clk = 1'b0;
  logic         rst, frame_start, pix_valid, calib, cmd_ready, wr_data_rdy;
  logic [15:0]  pix_data;
  logic [2:0]   cmd;
  logic         cmd_en, wr_data_en, wr_data_end, frame_done, overflow;
  logic [27:0]  addr;
  logic [5:0]   app_burst_number;
  logic [127:0] wr_data;
  logic [15:0]  wr_data_mask;
  logic [1:0]   last_frame_idx;

  always #5 clk = ~clk;

  frame_wr_dma #(.ADDR_WIDTH(28), .DATA_WIDTH(128), .BURST_LEN(16), .FIFO_DEPTH(32),
                 .FRAME_STRIDE(28'h0200000)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .init_calib_complete(calib), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .app_burst_number(app_burst_number),
    .wr_data_rdy(wr_data_rdy), .wr_data_en(wr_data_en), .wr_data(wr_data),
    .wr_data_end(wr_data_end), .wr_data_mask(wr_data_mask), .frame_done(frame_done),
    .last_frame_idx(last_frame_idx), .overflow(overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Handshake drivers: 0 low, 1 high, 2 toggle, 3 random, 4 driven by the main sequence
  int cmd_mode = 1;
  int rdy_mode = 1;

  logic [27:0]  act_cmd[$];
  logic [127:0] act_word[$];
  bit           act_end[$];
  logic [1:0]   act_done[$];
  int           done_at_word[$];
  int           cmd_en_cycles = 0;
  bit           bad_cmd = 1'b0;
  logic [15:0]  sent[$];

  typedef struct {
    int          npix;
    int          mode;
    logic [27:0] exp_addr;
    int          exp_bursts;
    bit          exp_done;
    logic [1:0]  exp_last;
  } vec_t;

  function automatic logic next_lvl(input int mode, input logic cur);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ~cur;
      3:       return 1'($urandom);
      default: return cur;
    endcase
  endfunction

  initial begin
    cmd_ready   = 1'b1;
    wr_data_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cmd_ready   = next_lvl(cmd_mode, cmd_ready);
      wr_data_rdy = next_lvl(rdy_mode, wr_data_rdy);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_en) begin
        cmd_en_cycles++;
        if (cmd !== 3'b000) bad_cmd = 1'b1;
      end
      if (cmd_en && cmd_ready) act_cmd.push_back(addr);
      if (wr_data_en) begin
        act_word.push_back(wr_data);
        act_end.push_back(wr_data_end);
      end
      if (frame_done) begin
        act_done.push_back(last_frame_idx);
        done_at_word.push_back(act_word.size());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    act_cmd.delete();
    act_word.delete();
    act_end.delete();
    act_done.delete();
    done_at_word.delete();
    cmd_en_cycles = 0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = '0;
    wait_cycles(2);
    rst = 1'b0;
    clear_mon();
  endtask

  // Pulse frame_start; returns in the first cycle pixels are accepted again.
  task automatic frame_begin();
    clear_mon();
    sent.delete();
    frame_start = 1'b1;
    wait_cycles(1);
    frame_start = 1'b0;
    wait_cycles(1);
  endtask

  task automatic send_pixels(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        pix_valid = 1'b0;
        wait_cycles(int'($urandom_range(0, 2)));
      end
      pix_valid = 1'b1;
      pix_data  = rnd ? 16'($urandom) : 16'(sent.size());
      sent.push_back(pix_data);
      wait_cycles(1);
    end
    pix_valid = 1'b0;
  endtask

  function automatic logic [127:0] model_word(input int w);
    logic [127:0] r = '0;
    for (int k = 0; k < 8; k++)
      if (8*w + k < sent.size()) r[16*k +: 16] = sent[8*w + k];
    return r;
  endfunction

  task automatic verify_frame(input string tag, input int bursts, input logic [27:0] base,
                              input bit exp_done, input logic [1:0] exp_last);
    check({tag, "_cmds"}, 128'(act_cmd.size()), 128'(bursts));
    for (int b = 0; b < act_cmd.size() && b < bursts; b++)
      check($sformatf("%s_addr%0d", tag, b), 128'(act_cmd[b]), 128'(base + 28'(b*128)));
    check({tag, "_words"}, 128'(act_word.size()), 128'(bursts*16));
    for (int i = 0; i < act_word.size() && i < bursts*16; i++) begin
      check($sformatf("%s_word%0d", tag, i), act_word[i], model_word(i));
      check($sformatf("%s_end%0d", tag, i), 128'(act_end[i]), 128'((i % 16) == 15));
    end
    check({tag, "_done"}, 128'(act_done.size()), 128'(exp_done));
    if (exp_done && act_done.size() > 0)
      check({tag, "_last_idx"}, 128'(act_done[0]), 128'(exp_last));
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{256, 1, 28'h0000000, 2, 1'b0, 2'd0};
    tbl[1] = '{128, 2, 28'h0200000, 1, 1'b1, 2'd0};
    tbl[2] = '{128, 1, 28'h0400000, 1, 1'b1, 2'd1};
    tbl[3] = '{128, 2, 28'h0000000, 1, 1'b1, 2'd2};

    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0; calib = 1'b1;
    wait_cycles(2);
    check("rst_cmd_en", 128'(cmd_en), 128'(0));
    check("rst_wr_data_en", 128'(wr_data_en), 128'(0));
    check("rst_wr_data_end", 128'(wr_data_end), 128'(0));
    check("rst_frame_done", 128'(frame_done), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_last_idx", 128'(last_frame_idx), 128'(0));
    check("burst_number", 128'(app_burst_number), 128'(15));
    check("data_mask", 128'(wr_data_mask), 128'(0));
    rst = 1'b0;
    clear_mon();

    // Frame sequence: consecutive pixels, constant or toggling data ready
    for (int i = 0; i < 4; i++) begin
      rdy_mode = tbl[i].mode;
      frame_begin();
      send_pixels(tbl[i].npix, 1'b0);
      wait_cycles(80);
      verify_frame($sformatf("tbl%0d", i), tbl[i].exp_bursts, tbl[i].exp_addr,
                   tbl[i].exp_done, tbl[i].exp_last);
    end
    rdy_mode = 1;

    // Overflow: commands stalled while 40 words arrive
    do_reset();
    cmd_mode = 0;
    frame_begin();
    send_pixels(256, 1'b0);
    wait_cycles(2);
    check("ovf_after_32", 128'(overflow), 128'(0));
    send_pixels(8, 1'b0);
    wait_cycles(2);
    check("ovf_after_33", 128'(overflow), 128'(1));
    send_pixels(56, 1'b0);
    cmd_mode = 1;
    wait_cycles(80);
    verify_frame("ovf", 2, 28'h0, 1'b0, 2'd0);
    check("ovf_sticky", 128'(overflow), 128'(1));
    frame_begin();
    check("ovf_cleared", 128'(overflow), 128'(0));

    // frame_start during a burst, after word 5
    do_reset();
    rdy_mode = 4;
    wr_data_rdy = 1'b0;
    frame_begin();
    send_pixels(152, 1'b0);
    wait_cycles(5);
    wr_data_rdy = 1'b1;
    wait_cycles(5);
    frame_start = 1'b1;
    wait_cycles(1);
    frame_start = 1'b0;
    wait_cycles(40);
    rdy_mode = 1;
    verify_frame("mid", 1, 28'h0, 1'b1, 2'd0);
    if (done_at_word.size() > 0)
      check("mid_done_after_burst", 128'(done_at_word[0]), 128'(16));
    clear_mon();
    sent.delete();
    send_pixels(104, 1'b0);
    wait_cycles(40);
    check("mid_flushed", 128'(act_cmd.size()), 128'(0));
    send_pixels(24, 1'b0);
    wait_cycles(40);
    verify_frame("mid_next", 1, 28'h0200000, 1'b0, 2'd0);

    // frame_start together with the 8th pixel of a word
    sent.delete();
    send_pixels(7, 1'b0);
    pix_valid = 1'b1; pix_data = 16'hBEEF; frame_start = 1'b1;
    wait_cycles(1);
    pix_valid = 1'b0; frame_start = 1'b0;
    wait_cycles(3);
    clear_mon();
    sent.delete();
    send_pixels(120, 1'b0);
    wait_cycles(40);
    check("coin_no_burst", 128'(act_cmd.size()), 128'(0));
    send_pixels(8, 1'b0);
    wait_cycles(40);
    verify_frame("coin", 1, 28'h0400000, 1'b0, 2'd0);

    // Calibration gating
    do_reset();
    calib = 1'b0;
    frame_begin();
    send_pixels(128, 1'b0);
    wait_cycles(20);
    check("calib_no_cmd", 128'(cmd_en_cycles), 128'(0));
    calib = 1'b1;
    @(negedge clk);
    check("calib_same_cycle", 128'(cmd_en), 128'(0));
    @(negedge clk);
    check("calib_next_cycle", 128'(cmd_en), 128'(1));
    @(posedge clk);
    #1;
    wait_cycles(40);
    verify_frame("calib", 1, 28'h0, 1'b0, 2'd0);

    // Reset in the middle of a burst
    rdy_mode = 0;
    sent.delete();
    send_pixels(128, 1'b0);
    wait_cycles(20);
    rdy_mode = 1;
    wait_cycles(5);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cmd_en", 128'(cmd_en), 128'(0));
    check("midrst_wr_data_en", 128'(wr_data_en), 128'(0));
    check("midrst_wr_data_end", 128'(wr_data_end), 128'(0));
    check("midrst_frame_done", 128'(frame_done), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    wait_cycles(30);
    check("midrst_no_cmd", 128'(cmd_en_cycles), 128'(0));
    check("midrst_no_data", 128'(act_word.size()), 128'(0));

    // Randomized frames with random handshakes against the frame-level model
    do_reset();
    cmd_mode = 3;
    rdy_mode = 3;
    for (int f = 0; f < 6; f++) begin
      int npix;
      npix = int'($urandom_range(0, 420));
      frame_begin();
      send_pixels(npix, 1'b1);
      wait_cycles(200);
      verify_frame($sformatf("rnd%0d", f), (npix / 8) / 16, 28'((f % 3) * 28'h0200000),
                   f >= 1, 2'((f + 2) % 3));
      check($sformatf("rnd%0d_no_ovf", f), 128'(overflow), 128'(0));
    end
    check("cmd_code_write", 128'(bad_cmd), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
